issue_scheduler: RTL and testbench

// In-order dual-issue scheduler between decode and the two execute units (unit A: ALU/branch, unit B: ALU/mem).

---
 rtl/issue_scheduler_pkg.sv | 27 ++
 rtl/issue_scheduler_if.sv | 53 +++++
 rtl/issue_scheduler_reg_scoreboard.sv | 48 ++++
 rtl/issue_scheduler.sv | 145 ++++++++++++++
 tb/tb_issue_scheduler.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/issue_scheduler_pkg.sv
// Shared definitions for the dual-issue scheduler.
//   REG_W          : architectural register index width
//   cls_e          : instruction class encoding as delivered by decode
//   unit_e         : execute unit identifiers (A = ALU/branch, B = ALU/mem)
//   norm_cls()     : folds the reserved class encoding onto ALU
package issue_scheduler_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    CLS_ALU = 2'd0,
    CLS_BR  = 2'd1,
    CLS_MEM = 2'd2,
    CLS_RSV = 2'd3
  } cls_e;

  typedef enum logic {
    UNIT_A = 1'b0,
    UNIT_B = 1'b1
  } unit_e;

  // The reserved encoding behaves exactly like a plain ALU op.
  function automatic cls_e norm_cls(input logic [1:0] raw);
    return (raw == 2'd3) ? CLS_ALU : cls_e'(raw);
  endfunction

endpackage

// File: rtl/issue_scheduler_if.sv
// Decode-to-execute bundle of the issue scheduler.
//   master : decode/execute environment (drives slots, stop, flush)
//   slave  : the scheduler (drives in_ready, launch outputs, hold_valid)
// Per slot N (1,2): valid, rs1, rs2, rd, we, cls, lat, payload.
interface issue_scheduler_if #(
  parameter int LAT_W = 3,
  parameter int PW    = 96
);
  import issue_scheduler_pkg::*;

  logic             stop;
  logic             flush;

  logic             in1_valid;
  logic [REG_W-1:0] in1_rs1;
  logic [REG_W-1:0] in1_rs2;
  logic [REG_W-1:0] in1_rd;
  logic             in1_we;
  logic [1:0]       in1_cls;
  logic [LAT_W-1:0] in1_lat;
  logic [PW-1:0]    in1_payload;

  logic             in2_valid;
  logic [REG_W-1:0] in2_rs1;
  logic [REG_W-1:0] in2_rs2;
  logic [REG_W-1:0] in2_rd;
  logic             in2_we;
  logic [1:0]       in2_cls;
  logic [LAT_W-1:0] in2_lat;
  logic [PW-1:0]    in2_payload;

  logic             in_ready;
  logic             ex_a_valid;
  logic [PW-1:0]    ex_a_payload;
  logic             ex_b_valid;
  logic [PW-1:0]    ex_b_payload;
  logic             hold_valid;

  modport master (
    output stop, flush,
    output in1_valid, in1_rs1, in1_rs2, in1_rd, in1_we, in1_cls, in1_lat, in1_payload,
    output in2_valid, in2_rs1, in2_rs2, in2_rd, in2_we, in2_cls, in2_lat, in2_payload,
    input  in_ready, ex_a_valid, ex_a_payload, ex_b_valid, ex_b_payload, hold_valid
  );

  modport slave (
    input  stop, flush,
    input  in1_valid, in1_rs1, in1_rs2, in1_rd, in1_we, in1_cls, in1_lat, in1_payload,
    input  in2_valid, in2_rs1, in2_rs2, in2_rd, in2_we, in2_cls, in2_lat, in2_payload,
    output in_ready, ex_a_valid, ex_a_payload, ex_b_valid, ex_b_payload, hold_valid
  );

endinterface

// File: rtl/issue_scheduler_reg_scoreboard.sv
// Latency-countdown register scoreboard.
//   clk, rst_n : clock, async active-low reset (all counters cleared)
//   en         : advance state this cycle (low = freeze)
//   ld_*       : two load ports, cnt[addr] <= lat-1 (load beats decrement)
//   rd_addr    : NRD lookup addresses, rd_busy[i] = cnt[rd_addr[i]] != 0
// x0 is never reported busy.
module reg_scoreboard
  import issue_scheduler_pkg::*;
#(
  parameter int NREG  = 32,
  parameter int LAT_W = 3,
  parameter int NRD   = 6
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic [1:0]                  ld_valid,
  input  logic [1:0][REG_W-1:0]       ld_addr,
  input  logic [1:0][LAT_W-1:0]       ld_lat,
  input  logic [NRD-1:0][REG_W-1:0]   rd_addr,
  output logic [NRD-1:0]              rd_busy
);

  logic [LAT_W-1:0] cnt_q [NREG];

  // NOTE: this array is functional state (a stale count stalls issue), so it
  // is reset like any other register rather than left as uninitialised RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
    end else if (en) begin
      for (int r = 0; r < NREG; r++) begin
        if (ld_valid[0] && ld_addr[0] == REG_W'(r))
          cnt_q[r] <= ld_lat[0] - LAT_W'(1);
        else if (ld_valid[1] && ld_addr[1] == REG_W'(r))
          cnt_q[r] <= ld_lat[1] - LAT_W'(1);
        else if (cnt_q[r] != '0)
          cnt_q[r] <= cnt_q[r] - LAT_W'(1);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NRD; i++)
      rd_busy[i] = (rd_addr[i] != '0) && (cnt_q[rd_addr[i]] != '0);
  end

endmodule

// File: rtl/issue_scheduler.sv
// In-order dual-issue scheduler: picks which decoded slots launch this cycle
// and onto which execute unit, parking a blocked slot-2 op in a one-entry
// hold buffer. Launch outputs are registered.
//   clk, rst_n : clock, async active-low reset
//   io (slave) : decode slots, stop/flush, in_ready, unit A/B launch, hold_valid
module issue_scheduler
  import issue_scheduler_pkg::*;
#(
  parameter int NREG  = 32,
  parameter int LAT_W = 3,
  parameter int PW    = 96
) (
  input logic              clk,
  input logic              rst_n,
  issue_scheduler_if.slave io
);

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic             we;
    cls_e             cls;
    logic [LAT_W-1:0] lat;
    logic [PW-1:0]    payload;
  } slot_t;

  slot_t         s1, s2, hold_q;
  logic          hold_valid_q;
  logic          ex_a_valid_q, ex_b_valid_q;
  logic [PW-1:0] ex_a_payload_q, ex_b_payload_q;

  logic          s1_go, s2_go, s2_unit_ok, raw, waw;
  unit_e         s1_unit, s2_unit;
  logic          a_go, b_go;
  logic [PW-1:0] a_payload, b_payload;
  logic          sb_en;
  logic [5:0]    busy;

  // Candidate slots: a held op has priority and issues alone.
  // NOTE: every variable is given a value before any branch so that no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    s1         = '0;
    s1.valid   = io.in1_valid;
    s1.rs1     = io.in1_rs1;
    s1.rs2     = io.in1_rs2;
    s1.rd      = io.in1_rd;
    s1.we      = io.in1_we;
    s1.cls     = norm_cls(io.in1_cls);
    s1.lat     = io.in1_lat;
    s1.payload = io.in1_payload;
    if (hold_valid_q) s1 = hold_q;

    s2         = '0;
    s2.valid   = !hold_valid_q && io.in1_valid && io.in2_valid;
    s2.rs1     = io.in2_rs1;
    s2.rs2     = io.in2_rs2;
    s2.rd      = io.in2_rd;
    s2.we      = io.in2_we;
    s2.cls     = norm_cls(io.in2_cls);
    s2.lat     = io.in2_lat;
    s2.payload = io.in2_payload;
  end

  // Lookups 0..2 serve slot 1 (rs1, rs2, rd), 3..5 serve slot 2.
  assign sb_en = !io.stop || io.flush;

  reg_scoreboard #(.NREG(NREG), .LAT_W(LAT_W), .NRD(6)) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (sb_en),
    .ld_valid ({s2_go && s2.we && s2.rd != '0, s1_go && s1.we && s1.rd != '0}),
    .ld_addr  ({s2.rd, s1.rd}),
    .ld_lat   ({s2.lat, s1.lat}),
    .rd_addr  ({s2.rd, s2.rs2, s2.rs1, s1.rd, s1.rs2, s1.rs1}),
    .rd_busy  (busy)
  );

  always_comb begin
    // ALU in slot 1 yields unit A when slot 2 is a branch that needs it.
    case (s1.cls)
      CLS_BR:  s1_unit = UNIT_A;
      CLS_MEM: s1_unit = UNIT_B;
      default: s1_unit = (s2.valid && s2.cls == CLS_BR) ? UNIT_B : UNIT_A;
    endcase
    s2_unit = (s1_unit == UNIT_A) ? UNIT_B : UNIT_A;

    case (s2.cls)
      CLS_BR:  s2_unit_ok = (s2_unit == UNIT_A);
      CLS_MEM: s2_unit_ok = (s2_unit == UNIT_B);
      default: s2_unit_ok = 1'b1;
    endcase

    raw = s1.we && s1.rd != '0 && (s2.rs1 == s1.rd || s2.rs2 == s1.rd);
    waw = s1.we && s2.we && s1.rd == s2.rd;

    s1_go = s1.valid && !io.stop && !io.flush &&
            !busy[0] && !busy[1] && !(s1.we && busy[2]);
    s2_go = s1_go && s2.valid && s2_unit_ok && !raw && !waw &&
            !busy[3] && !busy[4] && !(s2.we && busy[5]);

    a_go      = (s1_go && s1_unit == UNIT_A) || (s2_go && s2_unit == UNIT_A);
    b_go      = (s1_go && s1_unit == UNIT_B) || (s2_go && s2_unit == UNIT_B);
    a_payload = (s1_go && s1_unit == UNIT_A) ? s1.payload : s2.payload;
    b_payload = (s1_go && s1_unit == UNIT_B) ? s1.payload : s2.payload;
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_a_valid_q   <= 1'b0;
      ex_b_valid_q   <= 1'b0;
      ex_a_payload_q <= '0;
      ex_b_payload_q <= '0;
      hold_valid_q   <= 1'b0;
      hold_q         <= '0;
    end else if (io.flush) begin
      ex_a_valid_q <= 1'b0;
      ex_b_valid_q <= 1'b0;
      hold_valid_q <= 1'b0;
    end else if (!io.stop) begin
      ex_a_valid_q <= a_go;
      ex_b_valid_q <= b_go;
      if (a_go) ex_a_payload_q <= a_payload;
      if (b_go) ex_b_payload_q <= b_payload;
      if (hold_valid_q) begin
        if (s1_go) hold_valid_q <= 1'b0;
      end else if (s1_go && s2.valid && !s2_go) begin
        hold_valid_q <= 1'b1;
        hold_q       <= s2;
      end
    end
  end

  assign io.in_ready     = !hold_valid_q && s1_go;
  assign io.ex_a_valid   = ex_a_valid_q;
  assign io.ex_a_payload = ex_a_payload_q;
  assign io.ex_b_valid   = ex_b_valid_q;
  assign io.ex_b_payload = ex_b_payload_q;
  assign io.hold_valid   = hold_valid_q;

endmodule

// File: tb/tb_issue_scheduler.sv
// Self-checking bench for issue_scheduler: directed scenarios with literal
// expectations plus a randomised tail, all cross-checked every cycle against
// a ready-time register model.
module tb_issue_scheduler;

  localparam logic [1:0] ALU = 2'd0, BR = 2'd1, MEM = 2'd2;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        we;
    logic [1:0]  cls;
    logic [2:0]  lat;
    logic [95:0] payload;
  } tslot_t;

  localparam tslot_t NONE = '0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  issue_scheduler_if bus ();
  issue_scheduler dut (.clk(clk), .rst_n(rst_n), .io(bus));

  int n_cmp = 0;
  int n_bad = 0;

  tslot_t cur1, cur2;

  // Model state: a register is free once the active-cycle count reaches its ready time.
  int          m_ready [32];
  int          m_now;
  logic        m_hv;
  tslot_t      m_hold;
  logic        m_av, m_bv;
  logic [95:0] m_apl, m_bpl;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    check(name, 96'(act), 96'(exp));
  endtask

  function automatic tslot_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                input logic we, input logic [1:0] cls, input logic [2:0] lat,
                                input logic [95:0] pl);
    tslot_t s;
    s.valid = 1'b1; s.rs1 = rs1; s.rs2 = rs2; s.rd = rd; s.we = we;
    s.cls = cls; s.lat = lat; s.payload = pl;
    return s;
  endfunction

  task automatic drive(input tslot_t a, input tslot_t b);
    cur1 = a; cur2 = b;
    bus.in1_valid = a.valid; bus.in1_rs1 = a.rs1; bus.in1_rs2 = a.rs2; bus.in1_rd = a.rd;
    bus.in1_we = a.we; bus.in1_cls = a.cls; bus.in1_lat = a.lat; bus.in1_payload = a.payload;
    bus.in2_valid = b.valid; bus.in2_rs1 = b.rs1; bus.in2_rs2 = b.rs2; bus.in2_rd = b.rd;
    bus.in2_we = b.we; bus.in2_cls = b.cls; bus.in2_lat = b.lat; bus.in2_payload = b.payload;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Units as a mask: bit0 = A, bit1 = B.
  function automatic logic [1:0] need(input logic [1:0] cls);
    case (cls)
      BR:      return 2'b01;
      MEM:     return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  function automatic logic is_free(input logic [4:0] r);
    return (r == 5'd0) || (m_ready[r] <= m_now);
  endfunction

  task automatic m_reset();
    for (int r = 0; r < 32; r++) m_ready[r] = 0;
    m_now = 0; m_hv = 1'b0; m_hold = NONE;
    m_av = 1'b0; m_bv = 1'b0; m_apl = '0; m_bpl = '0;
  endtask

  task automatic model_step();
    tslot_t     c1, c2;
    logic       go1, go2, dep_ok;
    logic [1:0] n1, n2, u1, u2;
    c1 = m_hv ? m_hold : cur1;
    c2 = cur2;
    c2.valid = !m_hv && cur1.valid && cur2.valid;
    go1 = c1.valid && !bus.stop && !bus.flush && is_free(c1.rs1) && is_free(c1.rs2) &&
          (!c1.we || is_free(c1.rd));
    n1 = need(c1.cls);
    n2 = need(c2.cls);
    if (n1 != 2'b11)                   u1 = n1;
    else if (c2.valid && n2 == 2'b01)  u1 = 2'b10;
    else                               u1 = 2'b01;
    u2 = ~u1;
    dep_ok = is_free(c2.rs1) && is_free(c2.rs2) && (!c2.we || is_free(c2.rd)) &&
             !(c1.we && c1.rd != 5'd0 && (c2.rs1 == c1.rd || c2.rs2 == c1.rd)) &&
             !(c1.we && c2.we && c1.rd == c2.rd);
    go2 = go1 && c2.valid && dep_ok && ((n2 & u2) != 2'b00);

    check_bit("in_ready", bus.in_ready, !m_hv && go1);
    check_bit("ex_a_valid", bus.ex_a_valid, m_av);
    if (m_av) check("ex_a_payload", bus.ex_a_payload, m_apl);
    check_bit("ex_b_valid", bus.ex_b_valid, m_bv);
    if (m_bv) check("ex_b_payload", bus.ex_b_payload, m_bpl);
    check_bit("hold_valid", bus.hold_valid, m_hv);

    if (bus.flush) begin
      m_av = 1'b0; m_bv = 1'b0; m_hv = 1'b0;
      m_now++;
    end else if (!bus.stop) begin
      m_av = (go1 && u1 == 2'b01) || (go2 && u2 == 2'b01);
      m_bv = (go1 && u1 == 2'b10) || (go2 && u2 == 2'b10);
      if (m_av) m_apl = (go1 && u1 == 2'b01) ? c1.payload : c2.payload;
      if (m_bv) m_bpl = (go1 && u1 == 2'b10) ? c1.payload : c2.payload;
      if (go1 && c1.we && c1.rd != 5'd0) m_ready[c1.rd] = m_now + int'(c1.lat);
      if (go2 && c2.we && c2.rd != 5'd0) m_ready[c2.rd] = m_now + int'(c2.lat);
      if (m_hv) begin
        if (go1) m_hv = 1'b0;
      end else if (go1 && c2.valid && !go2) begin
        m_hv = 1'b1;
        m_hold = c2;
      end
      m_now++;
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      m_reset();
      check_bit("rst ex_a_valid", bus.ex_a_valid, 1'b0);
      check_bit("rst ex_b_valid", bus.ex_b_valid, 1'b0);
      check_bit("rst hold_valid", bus.hold_valid, 1'b0);
    end else begin
      model_step();
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    tslot_t a, b;
    logic   take;
    m_reset();
    bus.stop = 1'b0;
    bus.flush = 1'b0;
    drive(NONE, NONE);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_bit("reset in_ready", bus.in_ready, 1'b0);
    check_bit("reset ex_a_valid", bus.ex_a_valid, 1'b0);
    check_bit("reset ex_b_valid", bus.ex_b_valid, 1'b0);
    check_bit("reset hold_valid", bus.hold_valid, 1'b0);
    rst_n = 1'b1;

    // Dual ALU, no dependencies
    drive(mk(0, 0, 1, 1, ALU, 1, 96'h11), mk(0, 0, 2, 1, ALU, 1, 96'h22));
    #1 check_bit("dual in_ready", bus.in_ready, 1'b1);
    tick();
    check_bit("dual a_valid", bus.ex_a_valid, 1'b1);
    check("dual a_payload", bus.ex_a_payload, 96'h11);
    check_bit("dual b_valid", bus.ex_b_valid, 1'b1);
    check("dual b_payload", bus.ex_b_payload, 96'h22);

    // Intra-pair RAW: slot 2 parked, then issues from hold
    drive(mk(1, 2, 5, 1, ALU, 1, 96'h33), mk(5, 0, 6, 1, ALU, 1, 96'h44));
    #1 check_bit("raw in_ready", bus.in_ready, 1'b1);
    tick();
    check("raw a_payload", bus.ex_a_payload, 96'h33);
    check_bit("raw b_valid", bus.ex_b_valid, 1'b0);
    check_bit("raw hold_valid", bus.hold_valid, 1'b1);
    drive(NONE, NONE);
    #1 check_bit("raw hold in_ready", bus.in_ready, 1'b0);
    tick();
    check_bit("hold launch a_valid", bus.ex_a_valid, 1'b1);
    check("hold launch a_payload", bus.ex_a_payload, 96'h44);
    check_bit("hold cleared", bus.hold_valid, 1'b0);

    // MEM lat=3 producer, dependent consumer waits two cycles
    drive(mk(0, 0, 7, 1, MEM, 3, 96'h55), NONE);
    tick();
    check("mem b_payload", bus.ex_b_payload, 96'h55);
    check_bit("mem a_valid", bus.ex_a_valid, 1'b0);
    drive(mk(7, 0, 8, 1, ALU, 1, 96'h66), NONE);
    #1 check_bit("lat stall 1", bus.in_ready, 1'b0);
    tick();
    check_bit("lat stall 2", bus.in_ready, 1'b0);
    tick();
    check_bit("lat release", bus.in_ready, 1'b1);
    tick();
    check("lat consumer a_payload", bus.ex_a_payload, 96'h66);

    // ALU + BR: slot 1 moves to B so the branch can take A
    drive(mk(0, 0, 3, 1, ALU, 1, 96'h77), mk(0, 0, 4, 1, BR, 1, 96'h88));
    tick();
    check("alu_br b_payload", bus.ex_b_payload, 96'h77);
    check("alu_br a_payload", bus.ex_a_payload, 96'h88);
    check_bit("alu_br a_valid", bus.ex_a_valid, 1'b1);

    // MEM + MEM: slot 2 parked, then flushed out of hold
    drive(mk(0, 0, 10, 1, MEM, 1, 96'h99), mk(0, 0, 11, 1, MEM, 1, 96'hAA));
    tick();
    check("memmem b_payload", bus.ex_b_payload, 96'h99);
    check_bit("memmem a_valid", bus.ex_a_valid, 1'b0);
    check_bit("memmem hold", bus.hold_valid, 1'b1);
    drive(NONE, NONE);
    bus.flush = 1'b1;
    #1 check_bit("flush in_ready", bus.in_ready, 1'b0);
    tick();
    bus.flush = 1'b0;
    check_bit("flush hold", bus.hold_valid, 1'b0);
    check_bit("flush a_valid", bus.ex_a_valid, 1'b0);
    check_bit("flush b_valid", bus.ex_b_valid, 1'b0);

    // BR with WAW-conflicting ALU partner
    drive(mk(0, 0, 12, 1, BR, 1, 96'hB1), mk(0, 0, 12, 1, ALU, 1, 96'hB2));
    tick();
    check("waw a_payload", bus.ex_a_payload, 96'hB1);
    check_bit("waw hold", bus.hold_valid, 1'b1);
    drive(NONE, NONE);
    tick();
    check("waw hold a_payload", bus.ex_a_payload, 96'hB2);

    // Stop freezes outputs and counters for 4 cycles
    drive(mk(0, 0, 9, 1, ALU, 5, 96'hC1), NONE);
    tick();
    drive(mk(9, 0, 13, 1, ALU, 1, 96'hC2), NONE);
    bus.stop = 1'b1;
    #1 check_bit("stop in_ready", bus.in_ready, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_bit("stop a_valid held", bus.ex_a_valid, 1'b1);
      check("stop a_payload held", bus.ex_a_payload, 96'hC1);
    end
    bus.stop = 1'b0;
    #1 check_bit("post stop busy 0", bus.in_ready, 1'b0);
    tick();
    check_bit("post stop a_valid", bus.ex_a_valid, 1'b0);
    tick();
    tick();
    check_bit("post stop busy 3", bus.in_ready, 1'b0);
    tick();
    check_bit("post stop release", bus.in_ready, 1'b1);
    tick();
    check("post stop a_payload", bus.ex_a_payload, 96'hC2);

    // x0 destination never becomes busy
    drive(mk(0, 0, 0, 1, ALU, 5, 96'hE1), mk(0, 0, 16, 1, MEM, 1, 96'hE2));
    tick();
    check("x0 a_payload", bus.ex_a_payload, 96'hE1);
    check("x0 b_payload", bus.ex_b_payload, 96'hE2);
    drive(mk(0, 0, 0, 1, ALU, 1, 96'hE3), NONE);
    #1 check_bit("x0 not busy", bus.in_ready, 1'b1);
    tick();

    // Reset mid-run with a busy counter and an occupied hold
    drive(mk(0, 0, 10, 1, ALU, 7, 96'hD1), mk(10, 0, 14, 1, ALU, 1, 96'hD2));
    tick();
    check_bit("pre-reset hold", bus.hold_valid, 1'b1);
    drive(NONE, NONE);
    rst_n = 1'b0;
    #1;
    check_bit("midrst a_valid", bus.ex_a_valid, 1'b0);
    check_bit("midrst b_valid", bus.ex_b_valid, 1'b0);
    check_bit("midrst hold", bus.hold_valid, 1'b0);
    tick();
    rst_n = 1'b1;
    drive(mk(10, 0, 15, 1, ALU, 1, 96'hD3), NONE);
    #1 check_bit("midrst cnt cleared", bus.in_ready, 1'b1);
    tick();
    check("midrst a_payload", bus.ex_a_payload, 96'hD3);

    // Randomised tail; decode re-presents a pair until it is consumed
    take = 1'b1;
    a = NONE;
    b = NONE;
    for (int k = 0; k < 300; k++) begin
      if (take) begin
        a = mk(5'($urandom_range(7)), 5'($urandom_range(7)), 5'($urandom_range(7)),
               1'($urandom_range(1)), 2'($urandom_range(3)), 3'($urandom_range(4, 1)),
               {$urandom, $urandom, $urandom});
        b = mk(5'($urandom_range(7)), 5'($urandom_range(7)), 5'($urandom_range(7)),
               1'($urandom_range(1)), 2'($urandom_range(3)), 3'($urandom_range(4, 1)),
               {$urandom, $urandom, $urandom});
        a.valid = ($urandom_range(5) != 0);
        b.valid = a.valid && ($urandom_range(3) != 0);
      end
      bus.stop  = ($urandom_range(7) == 0);
      bus.flush = ($urandom_range(15) == 0);
      drive(a, b);
      @(negedge clk);
      take = bus.in_ready || bus.flush;
      @(posedge clk);
      #1;
    end
    bus.stop = 1'b0;
    bus.flush = 1'b0;
    drive(NONE, NONE);
    repeat (8) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
